cpu7_csr_intc: RTL and testbench

//  Interrupt/timer controller beside the CSR file. Owns the ECFG, ESTAT, TCFG, TVAL and TICLR CSRs.

---
 rtl/cpu7_csr_intc_pkg.sv | 32 +++
 rtl/cpu7_csr_timer.sv | 87 ++++++++
 rtl/cpu7_csr_intc.sv | 129 ++++++++++++
 tb/tb_cpu7_csr_intc.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu7_csr_intc_pkg.sv
// Shared CSR addresses, field positions and timer state encoding for the
// interrupt/timer controller slice.
package cpu7_csr_intc_pkg;

    localparam int CSR_BIT = 14;
    localparam int GRLEN   = 32;

    localparam logic [CSR_BIT-1:0] LSOC1K_CSR_ECFG  = 14'h004;
    localparam logic [CSR_BIT-1:0] LSOC1K_CSR_ESTAT = 14'h005;
    localparam logic [CSR_BIT-1:0] LSOC1K_CSR_TCFG  = 14'h041;
    localparam logic [CSR_BIT-1:0] LSOC1K_CSR_TVAL  = 14'h042;
    localparam logic [CSR_BIT-1:0] LSOC1K_CSR_TICLR = 14'h044;

    // ECFG.LIE / ESTAT.IS field layout
    localparam int ESTAT_IS_W     = 13;
    localparam int ESTAT_SW_W     = 2;
    localparam int ESTAT_HWI_LO   = 2;
    localparam int ESTAT_TI       = 11;
    localparam int ESTAT_IPI      = 12;

    // TCFG field layout
    localparam int TCFG_EN        = 0;
    localparam int TCFG_PER       = 1;
    localparam int TCFG_INITV_LO  = 2;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_RUN  = 2'd1,
        T_HALT = 2'd2
    } timer_state_e;

endpackage

// File: rtl/cpu7_csr_timer.sv
// Stable countdown timer: FSM, counter, reload and expiry pulse.
// A load (TCFG write) always overrides expiry in the same cycle.
module cpu7_csr_timer
    import cpu7_csr_intc_pkg::*;
#(
    parameter int TIMER_W = 30
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 load,
    input  logic                 en,
    input  logic                 periodic,
    input  logic [TIMER_W-1:0]   initval,
    output logic [TIMER_W+1:0]   count,
    output logic                 expire,
    output logic                 zero
);

    localparam int CW = TIMER_W + 2;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    timer_state_e    state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            zero_q,  zero_d;
    logic [CW-1:0]   reload;

    // Next state, next count and expiry event
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        expire  = 1'b0;
        reload  = {initval, 2'b00};
        if (load) begin
            count_d = reload;
            state_d = en ? T_RUN : T_IDLE;
        end else begin
            case (state_q)
                T_IDLE: begin
                    count_d = count_q;
                end
                T_RUN: begin
                    if (count_q == CNT_ONE) begin
                        count_d = '0;
                        expire  = 1'b1;
                        state_d = periodic ? T_RUN : T_HALT;
                    end else if (count_q == '0) begin
                        // Reached only via a zero load, or the cycle after a
                        // periodic expiry; the latter reloads silently.
                        if (!periodic) begin
                            expire  = 1'b1;
                            state_d = T_HALT;
                        end else begin
                            count_d = reload;
                            expire  = (initval == '0);
                        end
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
                T_HALT: begin
                    count_d = '0;
                end
                default: begin
                    state_d = T_IDLE;
                end
            endcase
        end
        zero_d = expire;
    end

    // Timer state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= T_IDLE;
            count_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    assign count = count_q;
    assign zero  = zero_q;

endmodule

// File: rtl/cpu7_csr_intc.sv
// Interrupt/timer controller: owns ECFG, ESTAT, TCFG, TVAL and TICLR,
// synchronises hardware interrupts and raises a level request to ecl.
module cpu7_csr_intc
    import cpu7_csr_intc_pkg::*;
#(
    parameter int TIMER_W = 30,
    parameter int HWI_N   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [CSR_BIT-1:0]   csr_waddr,
    input  logic [GRLEN-1:0]     csr_wdata,
    input  logic                 csr_wen,
    input  logic [CSR_BIT-1:0]   csr_raddr,
    output logic [GRLEN-1:0]     intc_csr_rdata,
    input  logic                 crmd_ie,
    input  logic [HWI_N-1:0]     hw_int,
    input  logic                 ipi,
    output logic                 intc_ecl_int_req,
    output logic                 intc_timer_zero
);

    localparam int TCFG_W = TIMER_W + 2;

    logic [ESTAT_IS_W-1:0]  lie_q,     lie_d;
    logic [ESTAT_SW_W-1:0]  sw_q,      sw_d;
    logic [TCFG_W-1:0]      tcfg_q,    tcfg_d;
    logic                   ti_q,      ti_d;
    logic [HWI_N-1:0]       hw_meta_q, hw_meta_d;
    logic [HWI_N-1:0]       hw_sync_q, hw_sync_d;
    logic                   ipi_q,     ipi_d;

    logic                   wr_ecfg, wr_estat, wr_tcfg, wr_ticlr;
    logic                   ti_clear;
    logic [ESTAT_IS_W-1:0]  estat_is;

    logic                   tmr_en, tmr_per;
    logic [TIMER_W-1:0]     tmr_initval;
    logic [TCFG_W-1:0]      tmr_count;
    logic                   tmr_expire, tmr_zero;

    // Write decode and next-state for all owned CSR fields
    always_comb begin
        wr_ecfg   = csr_wen && (csr_waddr == LSOC1K_CSR_ECFG);
        wr_estat  = csr_wen && (csr_waddr == LSOC1K_CSR_ESTAT);
        wr_tcfg   = csr_wen && (csr_waddr == LSOC1K_CSR_TCFG);
        wr_ticlr  = csr_wen && (csr_waddr == LSOC1K_CSR_TICLR);
        ti_clear  = wr_ticlr && csr_wdata[0];

        lie_d     = wr_ecfg  ? csr_wdata[ESTAT_IS_W-1:0] : lie_q;
        sw_d      = wr_estat ? csr_wdata[ESTAT_SW_W-1:0] : sw_q;
        tcfg_d    = wr_tcfg  ? csr_wdata[TCFG_W-1:0]     : tcfg_q;

        // Expiry set takes priority over a coincident TICLR clear
        ti_d      = tmr_expire ? 1'b1 : (ti_clear ? 1'b0 : ti_q);

        hw_meta_d = hw_int;
        hw_sync_d = hw_meta_q;
        ipi_d     = ipi;
    end

    // Timer configuration: the write data itself on a TCFG write, else the stored value
    always_comb begin
        tmr_en      = wr_tcfg ? csr_wdata[TCFG_EN]  : tcfg_q[TCFG_EN];
        tmr_per     = wr_tcfg ? csr_wdata[TCFG_PER] : tcfg_q[TCFG_PER];
        tmr_initval = wr_tcfg ? csr_wdata[TCFG_W-1:TCFG_INITV_LO]
                              : tcfg_q[TCFG_W-1:TCFG_INITV_LO];
    end

    // CSR field registers and interrupt synchronisers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lie_q     <= '0;
            sw_q      <= '0;
            tcfg_q    <= '0;
            ti_q      <= 1'b0;
            hw_meta_q <= '0;
            hw_sync_q <= '0;
            ipi_q     <= 1'b0;
        end else begin
            lie_q     <= lie_d;
            sw_q      <= sw_d;
            tcfg_q    <= tcfg_d;
            ti_q      <= ti_d;
            hw_meta_q <= hw_meta_d;
            hw_sync_q <= hw_sync_d;
            ipi_q     <= ipi_d;
        end
    end

    cpu7_csr_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (wr_tcfg),
        .en       (tmr_en),
        .periodic (tmr_per),
        .initval  (tmr_initval),
        .count    (tmr_count),
        .expire   (tmr_expire),
        .zero     (tmr_zero)
    );

    // Assemble ESTAT.IS from the registered sources
    always_comb begin
        estat_is                           = '0;
        estat_is[ESTAT_SW_W-1:0]           = sw_q;
        estat_is[ESTAT_HWI_LO +: HWI_N]    = hw_sync_q;
        estat_is[ESTAT_TI]                 = ti_q;
        estat_is[ESTAT_IPI]                = ipi_q;
    end

    // Same-cycle read mux; unowned addresses return 0
    always_comb begin
        intc_csr_rdata = '0;
        case (csr_raddr)
            LSOC1K_CSR_ECFG:  intc_csr_rdata = GRLEN'(lie_q);
            LSOC1K_CSR_ESTAT: intc_csr_rdata = GRLEN'(estat_is);
            LSOC1K_CSR_TCFG:  intc_csr_rdata = GRLEN'(tcfg_q);
            LSOC1K_CSR_TVAL:  intc_csr_rdata = GRLEN'(tmr_count);
            default:          intc_csr_rdata = '0;
        endcase
    end

    assign intc_ecl_int_req = crmd_ie & (|(estat_is & lie_q));
    assign intc_timer_zero  = tmr_zero;

endmodule

// File: tb/tb_cpu7_csr_intc.sv
module tb_cpu7_csr_intc;
    import cpu7_csr_intc_pkg::*;

    logic               clk;
    logic               resetn;
    logic [CSR_BIT-1:0] csr_waddr;
    logic [GRLEN-1:0]   csr_wdata;
    logic               csr_wen;
    logic [CSR_BIT-1:0] csr_raddr;
    logic [GRLEN-1:0]   intc_csr_rdata;
    logic               crmd_ie;
    logic [7:0]         hw_int;
    logic               ipi;
    logic               intc_ecl_int_req;
    logic               intc_timer_zero;

    int checks = 0;
    int errors = 0;

    cpu7_csr_intc #(
        .TIMER_W (30),
        .HWI_N   (8)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .csr_waddr        (csr_waddr),
        .csr_wdata        (csr_wdata),
        .csr_wen          (csr_wen),
        .csr_raddr        (csr_raddr),
        .intc_csr_rdata   (intc_csr_rdata),
        .crmd_ie          (crmd_ie),
        .hw_int           (hw_int),
        .ipi              (ipi),
        .intc_ecl_int_req (intc_ecl_int_req),
        .intc_timer_zero  (intc_timer_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [CSR_BIT-1:0] a, input logic [GRLEN-1:0] d);
        csr_waddr = a;
        csr_wdata = d;
        csr_wen   = 1'b1;
        tick();
        csr_wen   = 1'b0;
        csr_waddr = '0;
        csr_wdata = '0;
    endtask

    task automatic rd(input logic [CSR_BIT-1:0] a, output logic [GRLEN-1:0] d);
        csr_raddr = a;
        #1;
        d = intc_csr_rdata;
    endtask

    task automatic test_reset();
        logic [GRLEN-1:0] d;
        logic [CSR_BIT-1:0] addrs [5];
        addrs = '{LSOC1K_CSR_ECFG, LSOC1K_CSR_ESTAT, LSOC1K_CSR_TCFG,
                  LSOC1K_CSR_TVAL, LSOC1K_CSR_TICLR};
        for (int i = 0; i < 5; i++) begin
            rd(addrs[i], d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL reset_csr addr=%h got %h exp 0", addrs[i], d);
            end
        end
        checks++;
        if (intc_ecl_int_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req got %b exp 0", intc_ecl_int_req);
        end
        checks++;
        if (intc_timer_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_zero got %b exp 0", intc_timer_zero);
        end
    endtask

    task automatic test_rw_fields();
        logic [GRLEN-1:0] d;
        // read during the write cycle returns the old value
        csr_waddr = LSOC1K_CSR_ECFG;
        csr_wdata = 32'hFFFF_FFFF;
        csr_wen   = 1'b1;
        csr_raddr = LSOC1K_CSR_ECFG;
        #1;
        checks++;
        if (intc_csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL ecfg_read_in_write got %h exp 0", intc_csr_rdata);
        end
        tick();
        csr_wen = 1'b0;
        rd(LSOC1K_CSR_ECFG, d);
        checks++;
        if (d !== 32'h0000_1FFF) begin
            errors++;
            $display("FAIL ecfg_lie got %h exp 00001fff", d);
        end
        wr(LSOC1K_CSR_ESTAT, 32'hFFFF_FFFF);
        rd(LSOC1K_CSR_ESTAT, d);
        checks++;
        if (d !== 32'h0000_0003) begin
            errors++;
            $display("FAIL estat_sw_only got %h exp 00000003", d);
        end
        wr(LSOC1K_CSR_TVAL, 32'hFFFF_FFFF);
        rd(LSOC1K_CSR_TVAL, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL tval_ro got %h exp 0", d);
        end
        rd(LSOC1K_CSR_TCFG, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL tcfg_untouched got %h exp 0", d);
        end
        checks++;
        if (intc_ecl_int_req !== 1'b0) begin
            errors++;
            $display("FAIL sw_req_ie0 got %b exp 0", intc_ecl_int_req);
        end
        crmd_ie = 1'b1;
        #1;
        checks++;
        if (intc_ecl_int_req !== 1'b1) begin
            errors++;
            $display("FAIL sw_req_ie1 got %b exp 1", intc_ecl_int_req);
        end
        crmd_ie = 1'b0;
        wr(LSOC1K_CSR_ESTAT, 32'h0);
        wr(LSOC1K_CSR_ECFG, 32'h0);
    endtask

    task automatic test_oneshot();
        logic [GRLEN-1:0] d;
        wr(LSOC1K_CSR_TCFG, 32'h0000_000D);
        rd(LSOC1K_CSR_TVAL, d);
        checks++;
        if (d !== 32'd12) begin
            errors++;
            $display("FAIL oneshot_load got %0d exp 12", d);
        end
        for (int k = 11; k >= 0; k--) begin
            tick();
            rd(LSOC1K_CSR_TVAL, d);
            checks++;
            if (d !== 32'(k)) begin
                errors++;
                $display("FAIL oneshot_tval got %0d exp %0d", d, k);
            end
            checks++;
            if (intc_timer_zero !== (k == 0)) begin
                errors++;
                $display("FAIL oneshot_zero at %0d got %b exp %b", k, intc_timer_zero, (k == 0));
            end
            rd(LSOC1K_CSR_ESTAT, d);
            checks++;
            if (d[11] !== (k == 0)) begin
                errors++;
                $display("FAIL oneshot_ti at %0d got %b exp %b", k, d[11], (k == 0));
            end
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            rd(LSOC1K_CSR_TVAL, d);
            checks++;
            if (d !== 32'd0 || intc_timer_zero !== 1'b0) begin
                errors++;
                $display("FAIL oneshot_halt cyc %0d got tval %0d zero %b exp 0 0", i, d, intc_timer_zero);
            end
        end
        wr(LSOC1K_CSR_TICLR, 32'h1);
        rd(LSOC1K_CSR_ESTAT, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL oneshot_ticlr got %h exp 0", d);
        end
    endtask

    task automatic test_periodic();
        logic [GRLEN-1:0] d;
        int exp_seq [10] = '{3, 2, 1, 0, 4, 3, 2, 1, 0, 4};
        wr(LSOC1K_CSR_TCFG, 32'h0000_0007);
        rd(LSOC1K_CSR_TVAL, d);
        checks++;
        if (d !== 32'd4) begin
            errors++;
            $display("FAIL periodic_load got %0d exp 4", d);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            rd(LSOC1K_CSR_TVAL, d);
            checks++;
            if (d !== 32'(exp_seq[i]) || intc_timer_zero !== (exp_seq[i] == 0)) begin
                errors++;
                $display("FAIL periodic_seq step %0d got tval %0d zero %b exp %0d %b",
                         i, d, intc_timer_zero, exp_seq[i], (exp_seq[i] == 0));
            end
        end
        wr(LSOC1K_CSR_TCFG, 32'h0);
        tick();
        rd(LSOC1K_CSR_TVAL, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL periodic_stop got %0d exp 0", d);
        end
        wr(LSOC1K_CSR_TICLR, 32'h1);
    endtask

    task automatic test_irq_ti();
        logic [GRLEN-1:0] d;
        wr(LSOC1K_CSR_ECFG, 32'h0000_0800);
        crmd_ie = 1'b1;
        wr(LSOC1K_CSR_TCFG, 32'h0000_0005);
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (intc_ecl_int_req !== 1'b0) begin
            errors++;
            $display("FAIL irq_before_expiry got %b exp 0", intc_ecl_int_req);
        end
        tick();
        rd(LSOC1K_CSR_ESTAT, d);
        checks++;
        if (d[11] !== 1'b1 || intc_ecl_int_req !== 1'b1) begin
            errors++;
            $display("FAIL irq_ti_set got ti %b req %b exp 1 1", d[11], intc_ecl_int_req);
        end
        wr(LSOC1K_CSR_TICLR, 32'h1);
        checks++;
        if (intc_ecl_int_req !== 1'b0) begin
            errors++;
            $display("FAIL irq_ticlr got %b exp 0", intc_ecl_int_req);
        end
    endtask

    task automatic test_ticlr_race();
        logic [GRLEN-1:0] d;
        wr(LSOC1K_CSR_TCFG, 32'h0000_0005);
        for (int i = 0; i < 3; i++) tick();
        rd(LSOC1K_CSR_TVAL, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL race_pre got %0d exp 1", d);
        end
        wr(LSOC1K_CSR_TICLR, 32'h1);
        rd(LSOC1K_CSR_ESTAT, d);
        checks++;
        if (d[11] !== 1'b1 || intc_ecl_int_req !== 1'b1) begin
            errors++;
            $display("FAIL race_set_wins got ti %b req %b exp 1 1", d[11], intc_ecl_int_req);
        end
        wr(LSOC1K_CSR_TICLR, 32'h1);
        rd(LSOC1K_CSR_ESTAT, d);
        checks++;
        if (d[11] !== 1'b0) begin
            errors++;
            $display("FAIL race_clear_after got %b exp 0", d[11]);
        end
    endtask

    task automatic test_tcfg_collision();
        logic [GRLEN-1:0] d;
        wr(LSOC1K_CSR_TCFG, 32'h0000_0005);
        for (int i = 0; i < 3; i++) tick();
        wr(LSOC1K_CSR_TCFG, 32'h0000_0009);
        rd(LSOC1K_CSR_TVAL, d);
        checks++;
        if (d !== 32'd8) begin
            errors++;
            $display("FAIL coll_reload got %0d exp 8", d);
        end
        rd(LSOC1K_CSR_ESTAT, d);
        checks++;
        if (d[11] !== 1'b0 || intc_timer_zero !== 1'b0) begin
            errors++;
            $display("FAIL coll_no_ti got ti %b zero %b exp 0 0", d[11], intc_timer_zero);
        end
        tick();
        rd(LSOC1K_CSR_TVAL, d);
        checks++;
        if (d !== 32'd7) begin
            errors++;
            $display("FAIL coll_next got %0d exp 7", d);
        end
        wr(LSOC1K_CSR_TCFG, 32'h0);
    endtask

    task automatic test_load_zero_and_reset();
        logic [GRLEN-1:0] d;
        wr(LSOC1K_CSR_TCFG, 32'h0000_0001);
        rd(LSOC1K_CSR_ESTAT, d);
        checks++;
        if (d[11] !== 1'b0) begin
            errors++;
            $display("FAIL zero_load_early got %b exp 0", d[11]);
        end
        tick();
        rd(LSOC1K_CSR_ESTAT, d);
        checks++;
        if (d[11] !== 1'b1 || intc_timer_zero !== 1'b1) begin
            errors++;
            $display("FAIL zero_load_expire got ti %b zero %b exp 1 1", d[11], intc_timer_zero);
        end
        tick();
        rd(LSOC1K_CSR_TVAL, d);
        checks++;
        if (d !== 32'd0 || intc_timer_zero !== 1'b0) begin
            errors++;
            $display("FAIL zero_load_halt got tval %0d zero %b exp 0 0", d, intc_timer_zero);
        end
        wr(LSOC1K_CSR_TCFG, 32'h0000_0009);
        tick();
        rd(LSOC1K_CSR_TVAL, d);
        checks++;
        if (d !== 32'd7) begin
            errors++;
            $display("FAIL rst_pre got %0d exp 7", d);
        end
        resetn = 1'b0;
        #1;
        rd(LSOC1K_CSR_TVAL, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rst_tval got %0d exp 0", d);
        end
        rd(LSOC1K_CSR_ESTAT, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rst_estat got %h exp 0", d);
        end
        rd(LSOC1K_CSR_TCFG, d);
        checks++;
        if (d !== 32'd0 || intc_ecl_int_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_tcfg got %h req %b exp 0 0", d, intc_ecl_int_req);
        end
        tick();
        resetn = 1'b1;
        tick();
        tick();
        rd(LSOC1K_CSR_TVAL, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rst_idle got %0d exp 0", d);
        end
    endtask

    task automatic test_hwint();
        logic [GRLEN-1:0] d;
        logic seen;
        crmd_ie = 1'b1;
        hw_int  = 8'h08;
        tick();
        rd(LSOC1K_CSR_ESTAT, d);
        checks++;
        if (d[5] !== 1'b0) begin
            errors++;
            $display("FAIL hw_too_early got %b exp 0", d[5]);
        end
        seen = 1'b0;
        for (int c = 0; c < 2 && !seen; c++) begin
            tick();
            rd(LSOC1K_CSR_ESTAT, d);
            if (d[5] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1 || d !== 32'h0000_0020) begin
            errors++;
            $display("FAIL hw_sync got estat %h exp 00000020", d);
        end
        checks++;
        if (intc_ecl_int_req !== 1'b0) begin
            errors++;
            $display("FAIL hw_masked got %b exp 0", intc_ecl_int_req);
        end
        wr(LSOC1K_CSR_ECFG, 32'h0000_0020);
        checks++;
        if (intc_ecl_int_req !== 1'b1) begin
            errors++;
            $display("FAIL hw_enabled got %b exp 1", intc_ecl_int_req);
        end
        crmd_ie = 1'b0;
        #1;
        checks++;
        if (intc_ecl_int_req !== 1'b0) begin
            errors++;
            $display("FAIL hw_global_off got %b exp 0", intc_ecl_int_req);
        end
        crmd_ie = 1'b1;
        hw_int  = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        rd(LSOC1K_CSR_ESTAT, d);
        checks++;
        if (d !== 32'h0 || intc_ecl_int_req !== 1'b0) begin
            errors++;
            $display("FAIL hw_drop got estat %h req %b exp 0 0", d, intc_ecl_int_req);
        end
        ipi = 1'b1;
        tick();
        rd(LSOC1K_CSR_ESTAT, d);
        checks++;
        if (d !== 32'h0000_1000) begin
            errors++;
            $display("FAIL ipi_set got %h exp 00001000", d);
        end
        ipi = 1'b0;
        tick();
        rd(LSOC1K_CSR_ESTAT, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL ipi_clear got %h exp 0", d);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        csr_waddr = '0;
        csr_wdata = '0;
        csr_wen   = 1'b0;
        csr_raddr = '0;
        crmd_ie   = 1'b0;
        hw_int    = '0;
        ipi       = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        test_reset();
        test_rw_fields();
        test_oneshot();
        test_periodic();
        test_irq_ti();
        test_ticlr_race();
        test_tcfg_collision();
        test_load_zero_and_reset();
        test_hwint();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
